// File: rtl/led_mmio_port.sv
// Memory-mapped LED peripheral: 16-byte register window with static, blink
// and rotate display modes paced by a programmable prescaler.
module led_mmio_port #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
  parameter logic [31:0] DIV_RESET = 32'd49_999_999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  output logic        ack,
  output logic [7:0]  led
);

  localparam int unsigned DW = 32;
  localparam int unsigned LW = 8;
  localparam int unsigned MW = 2;

  localparam logic [1:0] SEL_DATA  = 2'd0;
  localparam logic [1:0] SEL_MODE  = 2'd1;
  localparam logic [1:0] SEL_DIV   = 2'd2;
  localparam logic [1:0] SEL_TICKS = 2'd3;

  localparam logic [MW-1:0] MODE_BLINK  = 2'd1;
  localparam logic [MW-1:0] MODE_ROTATE = 2'd2;

  logic [LW-1:0] r_data;
  logic [MW-1:0] r_mode;
  logic [DW-1:0] r_div;
  logic [DW-1:0] r_ticks;
  logic [DW-1:0] r_cnt;
  logic          r_phase;
  logic [LW-1:0] r_shown;
  logic [DW-1:0] r_rdata;
  logic          r_ack;

  logic          w_hit;
  logic          w_acc;
  logic [1:0]    w_sel;
  logic          w_wr_data;
  logic          w_wr_mode;
  logic          w_wr_div;
  logic          w_tick;
  logic [DW-1:0] w_rd_val;
  logic [LW-1:0] w_led;

  // Window decode; byte-lane bits fall out of the shift.
  assign w_hit     = (addr[31:4] == BASE_ADDR[31:4]);
  assign w_acc     = w_hit & (we | re);
  assign w_sel     = 2'(addr[3:0] >> 2);
  assign w_wr_data = w_hit & we & (w_sel == SEL_DATA);
  assign w_wr_mode = w_hit & we & (w_sel == SEL_MODE);
  assign w_wr_div  = w_hit & we & (w_sel == SEL_DIV);
  assign w_tick    = (r_cnt == r_div);

  // Register readback mux, pre-write values.
  always_comb begin
    w_rd_val = '0;
    case (w_sel)
      SEL_DATA:  w_rd_val = DW'(r_data);
      SEL_MODE:  w_rd_val = DW'(r_mode);
      SEL_DIV:   w_rd_val = r_div;
      SEL_TICKS: w_rd_val = r_ticks;
      default:   w_rd_val = '0;
    endcase
  end

  // Bus response: one-cycle ack, rdata zero outside a load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= w_acc;
      r_rdata <= (w_acc && re) ? w_rd_val : '0;
    end
  end

  // Software-visible configuration registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_mode <= '0;
      r_div  <= DIV_RESET;
    end else begin
      if (w_wr_data) r_data <= wdata[LW-1:0];
      if (w_wr_mode) r_mode <= wdata[MW-1:0];
      if (w_wr_div)  r_div  <= wdata;
    end
  end

  // Prescaler and free-running tick counter; config writes restart the period.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_ticks <= '0;
    end else begin
      if (w_wr_div || w_wr_mode || w_tick) r_cnt <= '0;
      else                                 r_cnt <= r_cnt + DW'(1);
      if (w_tick) r_ticks <= r_ticks + DW'(1);
    end
  end

  // Display state; bus writes take priority over a coincident tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shown <= '0;
      r_phase <= 1'b0;
    end else if (w_wr_data) begin
      r_shown <= wdata[LW-1:0];
      r_phase <= 1'b0;
    end else if (w_wr_mode) begin
      r_shown <= r_data;
      r_phase <= 1'b0;
    end else if (w_tick) begin
      if (r_mode == MODE_BLINK)  r_phase <= ~r_phase;
      if (r_mode == MODE_ROTATE) r_shown <= {r_shown[LW-2:0], r_shown[LW-1]};
    end
  end

  // LED drive decoded purely from display registers.
  always_comb begin
    w_led = r_shown;
    if ((r_mode == MODE_BLINK) && r_phase) w_led = '0;
  end

  assign rdata = r_rdata;
  assign ack   = r_ack;
  assign led   = w_led;

endmodule
